// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin scheduler sharing one serial signed multiplier among NREQ requesters
module mul_share_sched #(
  parameter int BITWIDTH = 8,
  parameter int NREQ = 4,
  parameter int TIMEOUT = 64,
  localparam int ID_W = $clog2(NREQ),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*BITWIDTH-1:0] req_a,
  input  logic [NREQ*BITWIDTH-1:0] req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     mul_start,
  output logic [BITWIDTH-1:0]      mul_a,
  output logic [BITWIDTH-1:0]      mul_b,
  input  logic                     mul_done,
  input  logic [2*BITWIDTH-1:0]    mul_result,
  output logic                     out_valid,
  output logic [ID_W-1:0]          out_id,
  output logic [2*BITWIDTH-1:0]    out_data,
  input  logic                     out_ready,
  output logic                     err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d, gnt_q, gnt_d, win;
  logic found;
  int idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BITWIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2*BITWIDTH-1:0] data_q, data_d;
  logic [NREQ-1:0] ready_q, ready_d;
  logic start_q, start_d, valid_q, valid_d, err_q, err_d;
  always_comb begin
    found = 1'b0;
    win = '0;
    idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(rr_q) + i) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win = ID_W'(idx);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    ready_d = '0;
    start_d = 1'b0;
    valid_d = valid_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (found) begin
        gnt_d = win;
        a_d = req_a[int'(win)*BITWIDTH +: BITWIDTH];
        b_d = req_b[int'(win)*BITWIDTH +: BITWIDTH];
        ready_d[win] = 1'b1;
        start_d = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (mul_done) begin
        data_d = mul_result;
        valid_d = 1'b1;
        state_d = RESP;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        data_d = '0;
        err_d = 1'b1;
        valid_d = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      RESP: if (out_ready) begin
        valid_d = 1'b0;
        rr_d = (gnt_q == ID_W'(NREQ - 1)) ? '0 : gnt_q + ID_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      ready_q <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
      ready_q <= ready_d;
      start_q <= start_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign req_ready = ready_q;
  assign mul_start = start_q;
  assign mul_a = a_q;
  assign mul_b = b_q;
  assign out_valid = valid_q;
  assign out_id = gnt_q;
  assign out_data = data_q;
  assign err = err_q;
endmodule

// File: tb/tb_mul_share_sched.sv
// tb_mul_share_sched: directed self-checking bench for mul_share_sched
module tb_mul_share_sched;
  localparam int L = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_valid = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [3:0] req_ready;
  logic mul_start;
  logic [7:0] mul_a, mul_b;
  logic mul_done = 1'b0;
  logic [15:0] mul_result = '0;
  logic out_valid;
  logic [1:0] out_id;
  logic [15:0] out_data;
  logic out_ready = 1'b0;
  logic err;
  bit mul_en = 1'b1;
  int total = 0, bad = 0, cyc = 0;
  logic [3:0] rdy;
  int pulses, lat;
  mul_share_sched #(.BITWIDTH(8), .NREQ(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result), .out_valid(out_valid), .out_id(out_id),
    .out_data(out_data), .out_ready(out_ready), .err(err)
  );
  always #5 clk = ~clk;
  initial begin
    logic [7:0] pa, pb;
    forever begin
      @(posedge clk);
      #1;
      if (mul_start && rst) begin
        pa = mul_a;
        pb = mul_b;
        for (int i = 0; i < L && rst; i++) @(posedge clk);
        if (rst && mul_en) begin
          #1;
          mul_result = 16'($signed(pa) * $signed(pb));
          mul_done = 1'b1;
          @(posedge clk);
          #1;
          mul_done = 1'b0;
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask
  task automatic serve(input bit drop, output logic [3:0] r, output int np, output int lt);
    int st = -1;
    r = '0;
    np = 0;
    for (int n = 0; n < 200 && !out_valid; n++) begin
      tick();
      if (req_ready != '0) begin
        np++;
        r = req_ready;
        if (drop) req_valid = req_valid & ~req_ready;
      end
      if (mul_start) st = cyc;
    end
    lt = cyc - st;
    chk("out_valid_reached", 64'(out_valid), 64'd1);
  endtask
  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_cleared", 64'(out_valid), 64'd0);
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {req_ready, mul_start, mul_a, mul_b, out_valid, out_id, out_data, err}, 64'd0);
  endtask
  initial begin
    logic [1:0] exp_id [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] exp_d [4] = '{16'h0006, 16'hFFF9, 16'hFF9C, 16'h00FE};
    #2 rst = 1'b0;
    tick();
    chk_zero("reset_outputs");
    rst = 1'b1;
    tick();
    chk_zero("idle_outputs");
    // single requester, negative operand
    set_op(2, 8'hFD, 8'h05);
    req_valid = 4'b0100;
    serve(1'b1, rdy, pulses, lat);
    chk("t1_ready", 64'(rdy), 64'h4);
    chk("t1_pulses", 64'(pulses), 64'd1);
    chk("t1_latency", 64'(lat), 64'(L + 1));
    chk("t1_ops", {mul_a, mul_b}, 64'hFD05);
    chk("t1_id", 64'(out_id), 64'd2);
    chk("t1_data", 64'(out_data), 64'hFFF1);
    chk("t1_err", 64'(err), 64'd0);
    accept();
    // round robin from reset with all requesters held
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_op(0, 8'd2, 8'd3);
    set_op(1, 8'hFF, 8'd7);
    set_op(2, 8'd10, 8'hF6);
    set_op(3, 8'd127, 8'd2);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      serve(1'b0, rdy, pulses, lat);
      chk("t2_ready", 64'(rdy), 64'(4'b0001 << exp_id[k]));
      chk("t2_id", 64'(out_id), 64'(exp_id[k]));
      chk("t2_data", 64'(out_data), 64'(exp_d[exp_id[k]]));
      accept();
    end
    req_valid = 4'b0000;
    // extreme operands
    set_op(0, 8'h80, 8'h80);
    req_valid = 4'b0001;
    serve(1'b1, rdy, pulses, lat);
    chk("t3_min_min", 64'(out_data), 64'h4000);
    accept();
    set_op(3, 8'h80, 8'h7F);
    req_valid = 4'b1000;
    serve(1'b1, rdy, pulses, lat);
    chk("t3_id", 64'(out_id), 64'd3);
    chk("t3_min_max", 64'(out_data), 64'hC080);
    accept();
    // backpressure in RESP with another request pending
    set_op(1, 8'd3, 8'd4);
    req_valid = 4'b0010;
    serve(1'b1, rdy, pulses, lat);
    set_op(2, 8'd1, 8'd1);
    req_valid = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("t4_hold", {out_valid, mul_start, req_ready, out_id, out_data}, {1'b1, 1'b0, 4'b0000, 2'd1, 16'h000C});
    end
    accept();
    serve(1'b1, rdy, pulses, lat);
    chk("t4_resume_id", 64'(out_id), 64'd2);
    chk("t4_resume_data", 64'(out_data), 64'h0001);
    accept();
    // timeout with no done
    mul_en = 1'b0;
    set_op(0, 8'd5, 8'd5);
    req_valid = 4'b0001;
    serve(1'b1, rdy, pulses, lat);
    chk("t5_wait_len", 64'(lat >= 64), 64'd1);
    chk("t5_id", 64'(out_id), 64'd0);
    chk("t5_data", 64'(out_data), 64'd0);
    chk("t5_err", 64'(err), 64'd1);
    accept();
    mul_en = 1'b1;
    set_op(1, 8'd2, 8'd2);
    req_valid = 4'b0010;
    serve(1'b1, rdy, pulses, lat);
    chk("t5_after_data", 64'(out_data), 64'h0004);
    chk("t5_err_sticky", 64'(err), 64'd1);
    accept();
    // reset mid-WAIT
    set_op(3, 8'd9, 8'd9);
    req_valid = 4'b1000;
    for (int n = 0; n < 50 && !mul_start; n++) tick();
    chk("t6_started", 64'(mul_start), 64'd1);
    req_valid = 4'b0000;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    chk_zero("t6_async_reset");
    tick();
    chk_zero("t6_reset_held");
    rst = 1'b1;
    set_op(0, 8'd6, 8'hFE);
    req_valid = 4'b1111;
    serve(1'b1, rdy, pulses, lat);
    chk("t6_ready", 64'(rdy), 64'h1);
    chk("t6_id", 64'(out_id), 64'd0);
    chk("t6_data", 64'(out_data), 64'hFFF4);
    chk("t6_err", 64'(err), 64'd0);
    req_valid = 4'b0000;
    accept();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
